// File: rtl/debug_uart_tx.sv
// Debug UART transmitter: sends a 9-byte frame (0xA5, seven snapshotted debug
// bytes, XOR checksum) as 8N1 characters, LSB first, with a registered tx line.
module debug_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       nreset,
    input  logic       start,
    input  logic [7:0] debug_port1,
    input  logic [7:0] debug_port2,
    input  logic [7:0] debug_port3,
    input  logic [7:0] debug_port4,
    input  logic [7:0] debug_port5,
    input  logic [7:0] debug_port6,
    input  logic [7:0] debug_port7,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BAUD_W-1:0] BAUD_ZERO = '0;
    localparam logic [7:0]        SYNC_BYTE = 8'hA5;
    localparam logic [3:0]        LAST_BYTE = 4'd8;
    localparam logic [2:0]        LAST_BIT  = 3'd7;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    // Frame checksum: XOR of the seven snapshot bytes.
    function automatic logic [7:0] xor_fold(input logic [6:0][7:0] bytes);
        return bytes[0] ^ bytes[1] ^ bytes[2] ^ bytes[3] ^
               bytes[4] ^ bytes[5] ^ bytes[6];
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        byte_idx_q, byte_idx_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [6:0][7:0]   snap_q, snap_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [7:0]        cur_byte_s;
    logic [7:0]        checksum_s;
    logic [2:0]        next_bit_s;
    logic              bit_end_s;

    // Select the byte currently on the line from the frame position.
    always_comb begin
        checksum_s = xor_fold(snap_q);
        case (byte_idx_q)
            4'd0:    cur_byte_s = SYNC_BYTE;
            4'd1:    cur_byte_s = snap_q[0];
            4'd2:    cur_byte_s = snap_q[1];
            4'd3:    cur_byte_s = snap_q[2];
            4'd4:    cur_byte_s = snap_q[3];
            4'd5:    cur_byte_s = snap_q[4];
            4'd6:    cur_byte_s = snap_q[5];
            4'd7:    cur_byte_s = snap_q[6];
            4'd8:    cur_byte_s = checksum_s;
            default: cur_byte_s = SYNC_BYTE;
        endcase
    end

    // Next-state logic; tx_d is the level the line takes for the coming bit.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = baud_q;
        snap_d     = snap_q;
        tx_d       = tx_q;
        done_d     = 1'b0;
        bit_end_s  = (baud_q == BAUD_LAST);
        next_bit_s = bit_idx_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = START_BIT;
                    snap_d     = {debug_port7, debug_port6, debug_port5,
                                  debug_port4, debug_port3, debug_port2,
                                  debug_port1};
                    byte_idx_d = 4'd0;
                    bit_idx_d  = 3'd0;
                    baud_d     = BAUD_ZERO;
                    tx_d       = 1'b0;
                end else begin
                    tx_d       = 1'b1;
                end
            end
            START_BIT: begin
                if (bit_end_s) begin
                    state_d   = DATA_BITS;
                    baud_d    = BAUD_ZERO;
                    bit_idx_d = 3'd0;
                    tx_d      = cur_byte_s[0];
                end else begin
                    baud_d    = baud_q + BAUD_ONE;
                end
            end
            DATA_BITS: begin
                if (bit_end_s) begin
                    baud_d = BAUD_ZERO;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d   = STOP_BIT;
                        bit_idx_d = 3'd0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = next_bit_s;
                        tx_d      = cur_byte_s[next_bit_s];
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            STOP_BIT: begin
                if (bit_end_s) begin
                    baud_d = BAUD_ZERO;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d    = IDLE;
                        byte_idx_d = 4'd0;
                        done_d     = 1'b1;
                        tx_d       = 1'b1;
                    end else begin
                        state_d    = START_BIT;
                        byte_idx_d = byte_idx_q + 4'd1;
                        tx_d       = 1'b0;
                    end
                end else begin
                    baud_d = baud_q + BAUD_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, counters, snapshot and output registers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= IDLE;
            byte_idx_q <= 4'd0;
            bit_idx_q  <= 3'd0;
            baud_q     <= BAUD_ZERO;
            snap_q     <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            snap_q     <= snap_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
